// File: rtl/mem_access_unit.sv
// Load/store unit that aligns CPU accesses onto a req/ack bus, with timeout and load extension.
// Latency: 3 cycles minimum (IDLE, REQ, DONE), plus one cycle per ack wait; the pipeline stalls until DONE.
module mem_access_unit #(
  parameter int TO_W = 8
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [2:0]  cpu_dm_ctrl,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        misalign_err,
  output logic        timeout_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  // Last REQ cycle: the counter starts at 0, so this gives 2^TO_W-1 REQ cycles.
  localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

  state_t          state, state_nxt;
  logic [TO_W-1:0] to_cnt;
  logic [31:0]     addr_q, wdata_q, rdata_q;
  logic [1:0]      addr_lo_q;
  logic [2:0]      ctrl_q;
  logic [3:0]      be_q;
  logic            we_q, mis_q, to_q;

  logic            is_half, is_byte, aligned;
  logic [31:0]     fmt_wdata, load_ext;
  logic [3:0]      fmt_be;
  logic [7:0]      byte_lane;
  logic [15:0]     half_lane;

  always_comb begin
    is_half   = (cpu_dm_ctrl == 3'b001) || (cpu_dm_ctrl == 3'b010);
    is_byte   = (cpu_dm_ctrl == 3'b011) || (cpu_dm_ctrl == 3'b100);
    fmt_wdata = cpu_wdata;
    fmt_be    = 4'b1111;
    aligned   = (cpu_addr[1:0] == 2'b00);
    if (is_byte) begin
      fmt_wdata = {4{cpu_wdata[7:0]}};
      fmt_be    = 4'b0001 << cpu_addr[1:0];
      aligned   = 1'b1;
    end else if (is_half) begin
      fmt_wdata = {2{cpu_wdata[15:0]}};
      fmt_be    = cpu_addr[1] ? 4'b1100 : 4'b0011;
      aligned   = ~cpu_addr[0];
    end
  end

  // Load lane selection uses the latched address, since cpu_addr may not be held for the whole access.
  always_comb begin
    case (addr_lo_q)
      2'd0:    byte_lane = bus_rdata[7:0];
      2'd1:    byte_lane = bus_rdata[15:8];
      2'd2:    byte_lane = bus_rdata[23:16];
      default: byte_lane = bus_rdata[31:24];
    endcase
    half_lane = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (ctrl_q)
      3'b001:  load_ext = {{16{half_lane[15]}}, half_lane};
      3'b010:  load_ext = {16'h0000, half_lane};
      3'b011:  load_ext = {{24{byte_lane[7]}}, byte_lane};
      3'b100:  load_ext = {24'h000000, byte_lane};
      default: load_ext = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (cpu_req) state_nxt = aligned ? REQ : DONE;
      REQ:     if (bus_ack || (to_cnt == TO_LAST)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      addr_q    <= '0;
      addr_lo_q <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      ctrl_q    <= '0;
      rdata_q   <= '0;
      mis_q     <= 1'b0;
      to_q      <= 1'b0;
      to_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (cpu_req) begin
          to_q    <= 1'b0;
          rdata_q <= '0;
          if (aligned) begin
            addr_q    <= {cpu_addr[31:2], 2'b00};
            addr_lo_q <= cpu_addr[1:0];
            wdata_q   <= fmt_wdata;
            be_q      <= fmt_be;
            we_q      <= cpu_we;
            ctrl_q    <= cpu_dm_ctrl;
            mis_q     <= 1'b0;
            to_cnt    <= '0;
          end else begin
            mis_q     <= 1'b1;
          end
        end
        REQ: begin
          if (bus_ack) begin
            rdata_q <= we_q ? 32'h0 : load_ext;
          end else if (to_cnt == TO_LAST) begin
            to_q    <= 1'b1;
            rdata_q <= '0;
          end else begin
            to_cnt  <= to_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Results are exposed only in DONE so the flags read as cleared everywhere else.
  always_comb begin
    bus_req      = (state == REQ);
    bus_we       = we_q & (state == REQ);
    bus_addr     = addr_q;
    bus_wdata    = wdata_q;
    bus_be       = be_q;
    cpu_stall    = resetn & (((state == IDLE) & cpu_req) | (state == REQ));
    cpu_rdata    = (state == DONE) ? rdata_q : 32'h0;
    misalign_err = (state == DONE) & mis_q;
    timeout_err  = (state == DONE) & to_q;
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized scoreboard bench for mem_access_unit with a width/lane-level reference model.
module tb_mem_access_unit;
  localparam int TO_W   = 4;
  localparam int TO_CYC = 15;

  logic        clk = 1'b0;
  logic        resetn;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [2:0]  cpu_dm_ctrl;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        misalign_err, timeout_err;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  mem_access_unit #(.TO_W(TO_W)) dut (
    .clk(clk), .resetn(resetn),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_dm_ctrl(cpu_dm_ctrl), .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata),
    .misalign_err(misalign_err), .timeout_err(timeout_err),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_be(bus_be), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] rdata; logic mis; logic to; int stall; } res_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; logic [3:0] be; int len; } bus_t;

  res_t res_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   failures = 0;
  logic mon_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size, alignment, lanes and extension from plain arithmetic.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [2:0] ctrl, input int waits, input logic [31:0] rd);
    int size, off;
    bit sgn, timed_out;
    logic [31:0] mask, lane;
    res_t r;
    bus_t b;
    sgn = 0;
    case (ctrl)
      3'd1: begin size = 2; sgn = 1; end
      3'd2: size = 2;
      3'd3: begin size = 1; sgn = 1; end
      3'd4: size = 1;
      default: size = 4;
    endcase
    off = int'(addr % 4);
    r.rdata = 32'h0; r.to = 1'b0; r.mis = 1'b0; r.stall = 1;
    if ((addr % size) != 0) begin
      r.mis = 1'b1;
    end else begin
      timed_out = (waits < 0) || (waits >= TO_CYC);
      b.len   = timed_out ? TO_CYC : waits + 1;
      b.addr  = addr & ~32'h3;
      b.we    = we;
      mask    = (size == 4) ? 32'hFFFF_FFFF : (size == 2) ? 32'h0000_FFFF : 32'h0000_00FF;
      b.wdata = (size == 4) ? wd : (size == 2) ? (wd & mask) * 32'h0001_0001 : (wd & mask) * 32'h0101_0101;
      b.be    = (size == 4) ? 4'hF : (size == 2) ? ((off >= 2) ? 4'hC : 4'h3) : 4'(1 << off);
      lane    = (rd >> (8 * off)) & mask;
      if (sgn && lane[8*size-1]) lane = lane | ~mask;
      r.rdata = (we || timed_out) ? 32'h0 : lane;
      r.to    = timed_out;
      r.stall = 1 + b.len;
      bus_q.push_back(b);
    end
    res_q.push_back(r);
  endtask

  // Drives one access and acts as the bus responder; waits<0 means never ack.
  task automatic do_access(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [2:0] ctrl, input int waits, input logic [31:0] rd,
                           input logic stale_ack);
    int n, cyc;
    bit done;
    model(we, addr, wd, ctrl, waits, rd);
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd; cpu_dm_ctrl = ctrl;
    bus_ack = stale_ack; bus_rdata = $urandom;
    n = 0; cyc = 0; done = 0;
    while (!done) begin
      @(posedge clk); #1;
      cyc++;
      if (!cpu_stall) begin
        done = 1;
      end else if (cyc > 100) begin
        checks++; failures++;
        $display("FAIL access_watchdog: still stalled after %0d cycles, required completion", cyc);
        done = 1;
      end else if (bus_req) begin
        bus_ack   = (n == waits);
        bus_rdata = (n == waits) ? rd : $urandom;
        n++;
      end else begin
        bus_ack = 1'b0;
      end
    end
    bus_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  // Monitor: bus transactions against bus_q, completions (DONE) against res_q.
  int   stall_cnt = 0, req_len = 0;
  logic prev_req = 1'b0;
  bus_t cur_bus;
  res_t cur_res;

  always @(negedge clk) begin
    if (!resetn || !mon_en) begin
      stall_cnt = 0;
      prev_req  = 1'b0;
    end else begin
      if (bus_req) begin
        if (!prev_req) begin
          req_len = 0;
          if (bus_q.size() == 0) begin
            chk("unexpected_bus_req", 32'(bus_req), 32'h0);
            cur_bus = '{addr: bus_addr, we: bus_we, wdata: bus_wdata, be: bus_be, len: 0};
          end else begin
            cur_bus = bus_q.pop_front();
          end
        end
        req_len++;
        chk("bus_addr", bus_addr, cur_bus.addr);
        chk("bus_be", 32'(bus_be), 32'(cur_bus.be));
        chk("bus_wdata", bus_wdata, cur_bus.wdata);
        chk("bus_we", 32'(bus_we), 32'(cur_bus.we));
      end else if (prev_req) begin
        chk("bus_req_len", 32'(req_len), 32'(cur_bus.len));
      end
      prev_req = bus_req;

      if (cpu_stall) begin
        stall_cnt++;
        chk("flags_outside_done", 32'({misalign_err, timeout_err}), 32'h0);
      end else if (cpu_req) begin
        if (res_q.size() == 0) begin
          chk("unexpected_done", 32'(cpu_req), 32'h0);
        end else begin
          cur_res = res_q.pop_front();
          chk("cpu_rdata", cpu_rdata, cur_res.rdata);
          chk("misalign_err", 32'(misalign_err), 32'(cur_res.mis));
          chk("timeout_err", 32'(timeout_err), 32'(cur_res.to));
          chk("stall_cycles", 32'(stall_cnt), 32'(cur_res.stall));
          chk("done_bus_req", 32'(bus_req), 32'h0);
        end
        stall_cnt = 0;
      end else begin
        stall_cnt = 0;
        chk("idle_flags", 32'({misalign_err, timeout_err, bus_req}), 32'h0);
      end
    end
  end

  initial begin
    resetn = 1'b0; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    cpu_dm_ctrl = 3'd0; bus_rdata = 32'h0; bus_ack = 1'b0;
    #12;
    chk("reset_outputs", 32'(|{bus_req, bus_we, bus_addr, bus_wdata, bus_be, cpu_rdata,
                              misalign_err, timeout_err, cpu_stall}), 32'h0);
    cpu_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    do_access(1'b0, 32'h100, 32'h0, 3'd0, 0, 32'hDEADBEEF, 1'b0);
    do_access(1'b0, 32'h103, 32'h0, 3'd3, 3, 32'h80112233, 1'b0);
    do_access(1'b0, 32'h103, 32'h0, 3'd4, 3, 32'h80112233, 1'b0);
    idle(1);
    do_access(1'b1, 32'h202, 32'h0000ABCD, 3'd1, 1, 32'h12345678, 1'b0);
    do_access(1'b0, 32'h101, 32'h0, 3'd0, 0, 32'h0, 1'b0);
    do_access(1'b0, 32'h104, 32'h0, 3'd2, -1, 32'h0, 1'b0);
    do_access(1'b0, 32'h106, 32'h0, 3'd1, 2, 32'hF00D1234, 1'b0);
    idle(2);

    for (int i = 0; i < 40; i++) begin
      do_access(1'($urandom), 32'h1000 + $urandom_range(0, 255), $urandom, 3'($urandom_range(0, 7)),
                (($urandom % 8) == 0) ? -1 : int'($urandom_range(0, 4)), $urandom, 1'b0);
      if (($urandom % 3) == 0) idle(int'($urandom_range(0, 2)));
    end

    // Reset in the second REQ cycle of a load that is never acked.
    @(posedge clk); #1;
    cpu_req = 1'b0;
    mon_en = 1'b0;
    @(posedge clk); #1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300; cpu_dm_ctrl = 3'd0; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_reset_bus_req", 32'(bus_req), 32'h1);
    #2 resetn = 1'b0;
    #1;
    chk("reset_drops_bus_req", 32'(bus_req), 32'h0);
    chk("reset_mid_outputs", 32'(|{bus_req, bus_we, bus_addr, bus_wdata, bus_be, cpu_rdata,
                                   misalign_err, timeout_err, cpu_stall}), 32'h0);
    @(posedge clk); #1;
    cpu_req = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    bus_ack = 1'b1;
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("stale_ack_idle", 32'({bus_req, cpu_stall}), 32'h0);
    res_q.delete();
    bus_q.delete();
    mon_en = 1'b1;
    do_access(1'b0, 32'h302, 32'h0, 3'd1, 2, 32'h8001_7FFF, 1'b1);
    do_access(1'b0, 32'h300, 32'h0, 3'd0, 0, 32'hCAFEF00D, 1'b0);
    idle(2);

    for (int i = 0; i < 50 && res_q.size() != 0; i++) @(posedge clk);
    chk("queues_drained", 32'(res_q.size() + bus_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Multi-cycle data-memory access unit between the pipelined CPU's MEM stage and a handshaked memory/peripheral bus. It accepts the CPU's load/store request (address, store data, write enable, dm_ctrl width code) and performs byte-lane alignment and byte enables. It runs a req/ack transaction with a timeout, sign- or zero-extends load data, and stalls the pipeline until the access completes. It replaces the single-cycle, always-ready data-memory assumption.

## Interface
- TO_W, default 8: timeout counter width; timeout fires after 2^TO_W-1 REQ cycles without ack.
- clk  in  1  rising-edge clock.
- resetn  in  1  reset, asynchronous, active-low.
- cpu_req  in  1  MEM stage holds a load or store.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_addr  in  32  byte address (ALU result).
- cpu_wdata  in  32  store data (forwarded rs2).
- cpu_dm_ctrl  in  3  width code: 000 word, 001 half, 010 half unsigned, 011 byte, 100 byte unsigned; 101–111 treated as word.
- cpu_stall  out  1  freeze PC and IF/ID, ID/EXE, EXE/MEM; combinational.
- cpu_rdata  out  32  extended load data; valid in DONE only.
- misalign_err  out  1  misaligned access; valid in DONE only.
- timeout_err  out  1  bus timeout; valid in DONE only.
- bus_req  out  1  transaction request.
- bus_we  out  1  write strobe.
- bus_addr  out  32  word address, {cpu_addr[31:2],2'b00}.
- bus_wdata  out  32  lane-replicated store data.
- bus_be  out  4  byte enables.
- bus_rdata  in  32  read data; sampled when bus_ack=1.
- bus_ack  in  1  transaction complete; one cycle.

## Operation
- States: IDLE, REQ, DONE.
- Alignment check: word needs addr[1:0]=00; half needs addr[0]=0; byte is always aligned.
- IDLE, cpu_req=1, aligned: latch addr, we, dm_ctrl, formatted wdata and be. Go to REQ. Clear timeout counter.
- IDLE, cpu_req=1, misaligned: go to DONE with misalign_err=1 and cpu_rdata=0. No bus activity.
- IDLE, cpu_req=0: stay in IDLE. bus_ack is ignored in IDLE.
- REQ: bus_req=1, with bus_addr/we/wdata/be stable from the latches.
  - On bus_ack=1: capture the extended read data (loads; stores capture 0) and go to DONE.
  - Otherwise the counter increments. At count 2^TO_W-1 with no ack, go to DONE with timeout_err=1 and cpu_rdata=0.
- DONE: cpu_stall=0, so the pipeline advances on this edge. Always go to IDLE next. cpu_req is ignored in DONE (it is still the same instruction). Error flags clear on leaving DONE.
- cpu_stall = (state==IDLE & cpu_req) | (state==REQ).
- Store formatting:
  - byte: wdata={4{d[7:0]}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{d[15:0]}}, be=addr[1]?1100:0011.
  - word: wdata=d, be=1111.
- Loads drive bus_be with the same pattern and bus_we=0.
- Load extraction:
  - byte lane = rdata[8*addr[1:0]+:8].
  - half lane = addr[1]?rdata[31:16]:rdata[15:0].
  - Sign-extend for 001/011, zero-extend for 010/100.
- Reset (any time, including mid-REQ): state=IDLE and bus_req drops immediately (asynchronous). bus_we, bus_addr, bus_wdata, bus_be, cpu_rdata, misalign_err and timeout_err are all 0. cpu_stall is forced 0 while resetn=0.

## Timing
- Minimum access is 3 cycles with ack in the first REQ cycle:
  - T0 IDLE: request seen, stall=1.
  - T1 REQ: bus_req=1, ack=1, stall=1.
  - T2 DONE: stall=0, cpu_rdata valid.
- Each ack wait cycle adds one stall cycle.
- Misaligned access takes 2 cycles (IDLE stall, DONE) with zero bus cycles.
- Timeout: bus_req is high for exactly 2^TO_W-1 cycles, then DONE.
- bus_req is registered. It deasserts the cycle after ack. It is never high in DONE or IDLE.
- Back-to-back requests: after DONE, IDLE accepts the next cpu_req in the same cycle it appears. There is a minimum of one non-REQ cycle between bus transactions.
- The MEM/WB register captures cpu_rdata on the DONE edge.

## Test plan
- Word load, addr 0x100, ack 1st REQ cycle, bus_rdata 0xDEADBEEF -> bus_addr=0x100, be=1111, we=0; stall high 2 cycles; DONE cpu_rdata=0xDEADBEEF.
- lb addr 0x103, rdata 0x80112233, ack after 3 waits -> be=1000, stall 5 cycles, cpu_rdata=0xFFFFFF80. Repeat with lbu -> 0x00000080.
- sh addr 0x202, wdata 0x0000ABCD -> bus_addr=0x200, be=1100, bus_wdata=0xABCDABCD, we=1; DONE cpu_rdata=0.
- lw addr 0x101 -> no bus_req ever; misalign_err=1 in DONE only; stall 1 cycle.
- TO_W=4, ack never -> bus_req high exactly 15 cycles; DONE timeout_err=1, cpu_rdata=0; returns to IDLE.
- resetn low in the 2nd REQ cycle -> bus_req=0 within the same cycle, all outputs 0; after release with cpu_req=1, a fresh transaction starts and a stale ack in IDLE is ignored.
